// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle RV32M divider.
//   - div_state_e : FSM state encodings (IDLE / BUSY / DONE)
//   - div_op_e    : op field codes (DIV / DIVU / REM / REMU)
//   - STALL_EX    : index of the EX-stage bit in the controller stall vector
//   - helpers decoding signedness and quotient/remainder selection from op
package div_unit_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  localparam int STALL_EX = 3;

  // DIV and REM (op[0] = 0) treat operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  // REM and REMU (op[1] = 1) return the remainder instead of the quotient.
  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// Conditional two's-complement negation. Used to take operand magnitudes
// before the iteration and to restore result signs afterwards.
//   value_i : XLEN-bit input value
//   neg_i   : 1 = negate, 0 = pass through
//   value_o : XLEN-bit output value
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] value_i,
  input  logic            neg_i,
  output logic [XLEN-1:0] value_o
);

  assign value_o = neg_i ? -value_i : value_i;

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV, DIVU, REM, REMU) living in the EX stage.
// Radix-2 restoring shift-subtract, one quotient bit per cycle. Requests a
// pipeline stall while a division is in flight and releases its result when
// the controller lets the EX instruction advance.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   start    : EX instruction is a divide/remainder (level)
//   op       : 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend : rs1 value
//   divisor  : rs2 value
//   annul    : flush of the EX instruction, aborts any operation
//   stall    : controller stall vector, bit STALL_EX = EX stage held
//   result   : quotient or remainder, valid while ready = 1, else 0
//   ready    : result valid this cycle
//   stallreq : EX-stage stall request to the controller
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            annul,
  input  logic [5:0]      stall,
  output logic [XLEN-1:0] result,
  output logic            ready,
  output logic            stallreq
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;   // divisor magnitude
  logic [1:0]        op_q, op_d;
  logic              q_neg_q, q_neg_d;
  logic              r_neg_q, r_neg_d;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN-1:0]   quo_fix, rem_fix;
  logic [XLEN:0]     partial, trial;
  logic              stall_unused;

  assign stall_unused = ^{stall[5:4], stall[2:0]};

  // Operand magnitudes for the unsigned core.
  assign a_neg = op_is_signed(op) & dividend[XLEN-1];
  assign b_neg = op_is_signed(op) & divisor[XLEN-1];

  div_sign_fix #(.XLEN(XLEN)) u_abs_a (.value_i(dividend), .neg_i(a_neg), .value_o(a_mag));
  div_sign_fix #(.XLEN(XLEN)) u_abs_b (.value_i(divisor),  .neg_i(b_neg), .value_o(b_mag));

  // Result sign restoration. The overflow case -2^31 / -1 falls out naturally:
  // the magnitude 0x80000000 negates back to itself.
  div_sign_fix #(.XLEN(XLEN)) u_fix_q (.value_i(quo_q), .neg_i(q_neg_q), .value_o(quo_fix));
  div_sign_fix #(.XLEN(XLEN)) u_fix_r (.value_i(rem_q), .neg_i(r_neg_q), .value_o(rem_fix));

  // The bit shifted out of rem is kept as bit XLEN so partial never overflows;
  // when the trial fails, partial < divisor and fits back into XLEN bits.
  assign partial = {rem_q, quo_q[XLEN-1]};
  assign trial   = partial - {1'b0, dsr_q};

  // NOTE: every *_d gets its hold value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    op_d    = op_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;

    if (annul) begin
      state_d = DIV_IDLE;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            op_d = op;
            if (divisor == '0) begin
              // Divide by zero: quotient all-ones, remainder = raw dividend.
              quo_d   = '1;
              rem_d   = dividend;
              q_neg_d = 1'b0;
              r_neg_d = 1'b0;
              state_d = DIV_DONE;
            end else begin
              quo_d   = a_mag;
              rem_d   = '0;
              dsr_d   = b_mag;
              q_neg_d = a_neg ^ b_neg;
              r_neg_d = a_neg;
              cnt_d   = CNT_W'(XLEN);
              state_d = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          if (!trial[XLEN]) begin
            rem_d = trial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = partial[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) state_d = DIV_DONE;
        end
        DIV_DONE: begin
          // Hold the result until the instruction leaves EX.
          if (!stall[STALL_EX]) state_d = DIV_IDLE;
        end
        default: state_d = DIV_IDLE;
      endcase
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      op_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      op_q    <= op_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
    end
  end

  assign ready    = (state_q == DIV_DONE) & ~annul;
  assign result   = ready ? (op_is_rem(op_q) ? rem_fix : quo_fix) : '0;
  assign stallreq = start & ~annul & (state_q != DIV_DONE);

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        annul;
  logic [5:0]  stall;
  logic [31:0] result;
  logic        ready;
  logic        stallreq;

  int total = 0;
  int bad   = 0;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .annul    (annul),
    .stall    (stall),
    .result   (result),
    .ready    (ready),
    .stallreq (stallreq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start must never fall while BUSY unless the instruction is annulled.
  always @(negedge clk) begin
    if (!rst && dut.state_q == DIV_BUSY && !start && !annul) begin
      bad++;
      $error("FAIL start_drop: start=0 while busy, required 1");
    end
  end

  // Issues one op at its t0 (call at posedge+1 with the unit idle), waits for
  // ready, checks result/latency/stall-request count, then retires it with
  // stall[3]=0 and checks ready was a single-cycle pulse.
  task automatic run_div(input string tag, input logic [1:0] o,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int exp_lat);
    int lat;
    int sr;
    op = o; dividend = a; divisor = b; start = 1'b1; annul = 1'b0; stall = '0;
    #1;
    sr  = stallreq ? 1 : 0;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk);
      #2;
      lat++;
      if (stallreq) sr++;
    end
    check({tag, "_result"}, result, exp);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_stallreq_cycles"}, 32'(sr), 32'(exp_lat));
    tick();
    start = 1'b0;
    #1;
    check({tag, "_ready_pulse"}, {31'b0, ready}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    annul = 1'b0; stall = '0;
    tick();
    tick();
    check("reset_result",   result, 32'd0);
    check("reset_ready",    {31'b0, ready}, 32'd0);
    check("reset_stallreq", {31'b0, stallreq}, 32'd0);
    rst = 1'b0;

    // Basic unsigned divide.
    tick(); run_div("divu_100_7", DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33);

    // Signed and unsigned with negative operands.
    tick(); run_div("rem_m7_2",   DIV_OP_REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    tick(); run_div("div_m7_2",   DIV_OP_DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    tick(); run_div("remu_fff9_2",DIV_OP_REMU, 32'hFFFFFFF9, 32'd2, 32'd1, 33);
    tick(); run_div("div_7_m2",   DIV_OP_DIV,  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    tick(); run_div("rem_7_m2",   DIV_OP_REM,  32'd7, 32'hFFFFFFFE, 32'd1, 33);
    tick(); run_div("divu_max_1", DIV_OP_DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33);
    tick(); run_div("remu_max_big", DIV_OP_REMU, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 33);

    // Signed overflow.
    tick(); run_div("div_ovf", DIV_OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33);
    tick(); run_div("rem_ovf", DIV_OP_REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33);

    // Divide by zero.
    tick(); run_div("div_5_0",   DIV_OP_DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1);
    tick(); run_div("remu_5_0",  DIV_OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    tick(); run_div("rem_m7_0",  DIV_OP_REM,  32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 1);

    // Annul at t10, then a new op issued on the very next cycle.
    tick();
    op = DIV_OP_DIVU; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    annul = 1'b1;
    #1;
    check("annul_ready",    {31'b0, ready}, 32'd0);
    check("annul_stallreq", {31'b0, stallreq}, 32'd0);
    tick();
    annul = 1'b0;
    run_div("divu_9_3_after_annul", DIV_OP_DIVU, 32'd9, 32'd3, 32'd3, 33);

    // Result held in DONE while EX is stalled.
    tick();
    op = DIV_OP_DIV; dividend = 32'd100; divisor = 32'hFFFFFFF9; start = 1'b1;
    #1;
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clk);
      #2;
      lat++;
    end
    check("hold_latency", 32'(lat), 32'd33);
    stall = 6'b001000;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("hold_ready",  {31'b0, ready}, 32'd1);
      check("hold_result", result, 32'hFFFFFFF2);
    end
    stall = '0;
    tick();
    start = 1'b0;
    #1;
    check("hold_release_ready", {31'b0, ready}, 32'd0);

    // Reset mid-operation at t15.
    tick();
    op = DIV_OP_REMU; dividend = 32'd1234; divisor = 32'd10; start = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    rst = 1'b1; start = 1'b0;
    tick();
    check("midrst_result",   result, 32'd0);
    check("midrst_ready",    {31'b0, ready}, 32'd0);
    check("midrst_stallreq", {31'b0, stallreq}, 32'd0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ready) seen++;
    end
    check("midrst_no_pulse", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
